// File: rtl/pga_spi_writer.sv
// pga_spi_writer: serialises a PGA gain code to the AFE over a write-only,
// mode-0 SPI link. The frame is {CMD_BYTE, code} and goes out MSB first.
// The block reports busy/done to the signal-chain controller and keeps a
// copy of the code currently held by the PGA.
module pga_spi_writer #(
  parameter int                CLK_FREQ   = 100_000_000,
  parameter int                SCLK_FREQ  = 10_000_000,
  parameter int                CODE_W     = 8,
  parameter logic [7:0]        CMD_BYTE   = 8'h40,
  parameter logic [CODE_W-1:0] RESET_CODE = '0,
  parameter bit                SKIP_SAME  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_i,
  input  logic              set_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              dropped_o,
  output logic [CODE_W-1:0] code_o,
  output logic              spi_cs_n_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o
);

  // Half SCLK period in system clocks.
  localparam int H      = (SCLK_FREQ > 0) ? CLK_FREQ / (2 * SCLK_FREQ) : 0;
  localparam int HCNT_W = (H > 1) ? $clog2(H) : 1;

  localparam logic [HCNT_W-1:0] H_LOAD   = HCNT_W'(H - 1);
  localparam logic [4:0]        LAST_BIT = 5'd15;
  localparam logic [4:0]        ALL_BITS = 5'd16;

  // Refuse to build with an SCLK that is not an exact even divisor of clk.
  if (H < 1 || (2 * SCLK_FREQ * H) != CLK_FREQ) begin : g_bad_sclk
    $error("pga_spi_writer: CLK_FREQ/(2*SCLK_FREQ) must be an integer >= 1");
  end

  // The frame carries the code in an 8-bit field.
  if (CODE_W < 1 || CODE_W > 8) begin : g_bad_code_w
    $error("pga_spi_writer: CODE_W must be in 1..8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_RECOVER,
    S_DONE
  } state_t;

  // Write frame: command byte followed by the zero-extended gain code.
  function automatic logic [15:0] build_frame(input logic [CODE_W-1:0] code);
    return {CMD_BYTE, 8'(code)};
  endfunction

  state_t              state, state_nxt;
  logic [HCNT_W-1:0]   hcnt, hcnt_nxt;
  logic [4:0]          bit_cnt, bit_nxt;
  logic                cs_n_nxt, sclk_nxt, mosi_nxt;
  logic                load, shift, commit;
  logic                hcnt_zero;
  logic [15:0]         frame_w;
  logic [14:0]         sr;
  logic [CODE_W-1:0]   pend_code;

  assign frame_w   = build_frame(code_i);
  assign hcnt_zero = (hcnt == '0);

  // Next-state, counter and pin decisions; every phase lasts H clocks.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    bit_nxt   = bit_cnt;
    cs_n_nxt  = spi_cs_n_o;
    sclk_nxt  = spi_sclk_o;
    mosi_nxt  = spi_mosi_o;
    load      = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;

    case (state)
      S_IDLE: begin
        if (set_i) begin
          load = 1'b1;
          if (SKIP_SAME && (code_i == code_o)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SETUP;
            hcnt_nxt  = H_LOAD;
            bit_nxt   = '0;
            cs_n_nxt  = 1'b0;
            sclk_nxt  = 1'b0;
            mosi_nxt  = frame_w[15];
          end
        end
      end

      S_SETUP: begin
        if (hcnt_zero) begin
          state_nxt = S_SHIFT;
          hcnt_nxt  = H_LOAD;
          sclk_nxt  = 1'b1;
        end else begin
          hcnt_nxt = hcnt - HCNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (!hcnt_zero) begin
          hcnt_nxt = hcnt - HCNT_W'(1);
        end else if (spi_sclk_o) begin
          // Falling edge: present the next bit; after the last bit the low
          // phase is CS hold time and mosi is parked at 0.
          sclk_nxt = 1'b0;
          hcnt_nxt = H_LOAD;
          bit_nxt  = bit_cnt + 5'd1;
          shift    = 1'b1;
          mosi_nxt = (bit_cnt == LAST_BIT) ? 1'b0 : sr[14];
        end else if (bit_cnt == ALL_BITS) begin
          state_nxt = S_RECOVER;
          hcnt_nxt  = H_LOAD;
          cs_n_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
        end else begin
          sclk_nxt = 1'b1;
          hcnt_nxt = H_LOAD;
        end
      end

      S_RECOVER: begin
        if (hcnt_zero) begin
          state_nxt = S_DONE;
        end else begin
          hcnt_nxt = hcnt - HCNT_W'(1);
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        commit    = 1'b1;
        hcnt_nxt  = '0;
        bit_nxt   = '0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, counters and registered pins; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      bit_cnt    <= '0;
      spi_cs_n_o <= 1'b1;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      dropped_o  <= 1'b0;
      code_o     <= RESET_CODE;
    end else begin
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      bit_cnt    <= bit_nxt;
      spi_cs_n_o <= cs_n_nxt;
      spi_sclk_o <= sclk_nxt;
      spi_mosi_o <= mosi_nxt;
      busy_o     <= (state_nxt != S_IDLE);
      done_o     <= (state_nxt == S_DONE);
      dropped_o  <= set_i && (state != S_IDLE);
      if (commit) begin
        code_o <= pend_code;
      end
    end
  end

  // Frame data: loaded on accept, shifted left at every falling sclk edge.
  always_ff @(posedge clk) begin
    if (load) begin
      sr        <= frame_w[14:0];
      pend_code <= code_i;
    end else if (shift) begin
      sr <= {sr[13:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_pga_spi_writer.sv
// Testbench for pga_spi_writer: two instances (H=2 and H=1) driven by
// directed and random requests; each transaction is checked against the
// expected frame, busy/cs timing and code bookkeeping.
module tb_pga_spi_writer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] code2, code1;
  logic       set2, set1;
  logic       busy2, done2, drop2, cs2, sclk2, mosi2;
  logic       busy1, done1, drop1, cs1, sclk1, mosi1;
  logic [7:0] codeo2, codeo1;

  always #5 clk = ~clk;

  pga_spi_writer #(
    .CLK_FREQ(100_000_000), .SCLK_FREQ(25_000_000), .CODE_W(8),
    .CMD_BYTE(8'h40), .RESET_CODE(8'h00), .SKIP_SAME(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .code_i(code2), .set_i(set2),
    .busy_o(busy2), .done_o(done2), .dropped_o(drop2), .code_o(codeo2),
    .spi_cs_n_o(cs2), .spi_sclk_o(sclk2), .spi_mosi_o(mosi2)
  );

  pga_spi_writer #(
    .CLK_FREQ(100_000_000), .SCLK_FREQ(50_000_000), .CODE_W(8),
    .CMD_BYTE(8'h40), .RESET_CODE(8'h00), .SKIP_SAME(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .code_i(code1), .set_i(set1),
    .busy_o(busy1), .done_o(done1), .dropped_o(drop1), .code_o(codeo1),
    .spi_cs_n_o(cs1), .spi_sclk_o(sclk1), .spi_mosi_o(mosi1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Which instance the monitor looks at: 1 -> H=1, 2 -> H=2.
  int sel_h = 2;

  // Reference state: code each PGA should hold.
  logic [7:0] model1 = 8'h00;
  logic [7:0] model2 = 8'h00;

  logic       m_busy, m_done, m_drop, m_cs_n, m_sclk, m_mosi;
  logic [7:0] m_code;

  assign m_busy = (sel_h == 1) ? busy1  : busy2;
  assign m_done = (sel_h == 1) ? done1  : done2;
  assign m_drop = (sel_h == 1) ? drop1  : drop2;
  assign m_cs_n = (sel_h == 1) ? cs1    : cs2;
  assign m_sclk = (sel_h == 1) ? sclk1  : sclk2;
  assign m_mosi = (sel_h == 1) ? mosi1  : mosi2;
  assign m_code = (sel_h == 1) ? codeo1 : codeo2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] c);
    if (sel_h == 1) begin
      set1  = s;
      code1 = c;
    end else begin
      set2  = s;
      code2 = c;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one request at the current negedge and follow it until busy drops.
  // drop_at > 0 raises a second (code 00) request during that busy cycle.
  // Returns at the negedge of the first idle cycle.
  task automatic transact(input int h, input logic [7:0] code, input int drop_at);
    logic [7:0]  old_code;
    logic [15:0] frame, got_bits;
    bit          exp_skip, ended;
    int          exp_busy, exp_cs, exp_rises, exp_drops;
    int          busy_len, cs_low, done_cnt, done_k, rises, unstable, drops, early;
    logic        prev_sclk, prev_mosi;

    sel_h     = h;
    old_code  = (h == 1) ? model1 : model2;
    exp_skip  = (code == old_code);
    frame     = {8'h40, code};
    exp_busy  = exp_skip ? 1 : 34 * h + 1;
    exp_cs    = exp_skip ? 0 : 33 * h;
    exp_rises = exp_skip ? 0 : 16;
    exp_drops = (drop_at > 0 && drop_at <= exp_busy) ? 1 : 0;

    busy_len = 0; cs_low = 0; done_cnt = 0; done_k = 0;
    rises = 0; unstable = 0; drops = 0; early = 0;
    got_bits  = '0;
    ended     = 1'b0;
    prev_sclk = m_sclk;
    prev_mosi = m_mosi;

    drive(1'b1, code);
    for (int k = 1; k <= 40 * h + 10 && !ended; k++) begin
      @(negedge clk);
      if (k == drop_at) drive(1'b1, 8'h00);
      else              drive(1'b0, code);
      if (k == 1) check("first_busy", m_busy, 1);
      if (m_busy === 1'b1) begin
        busy_len++;
        if (m_code !== old_code) early++;
      end else begin
        ended = 1'b1;
      end
      if (m_cs_n === 1'b0) cs_low++;
      if (m_done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
      if (m_drop === 1'b1) drops++;
      if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        got_bits = {got_bits[14:0], m_mosi};
        if (m_mosi !== prev_mosi) unstable++;
      end
      if (m_sclk === 1'b1 && prev_sclk === 1'b1 && m_mosi !== prev_mosi) unstable++;
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
    end

    check("ended_in_budget", ended, 1);
    check("busy_len", busy_len, exp_busy);
    check("cs_low_cycles", cs_low, exp_cs);
    check("done_count", done_cnt, 1);
    check("done_in_last_busy", done_k, exp_busy);
    check("sclk_rises", rises, exp_rises);
    if (!exp_skip) check("frame_bits", got_bits, frame);
    check("mosi_unstable", unstable, 0);
    check("dropped_count", drops, exp_drops);
    check("code_o_early_change", early, 0);
    check("code_o_after", m_code, code);

    if (h == 1) model1 = code;
    else        model2 = code;
  endtask

  initial begin
    int   h;
    int   drop_at;
    logic [7:0] code;

    rst   = 1'b1;
    set1  = 1'b0; code1 = 8'h00;
    set2  = 1'b0; code2 = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Reset state
    sel_h = 2;
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_dropped", m_drop, 0);
    check("rst_code", m_code, 8'h00);
    check("rst_cs_n", m_cs_n, 1);
    check("rst_sclk", m_sclk, 0);
    check("rst_mosi", m_mosi, 0);
    sel_h = 1;
    check("rst_cs_n_h1", m_cs_n, 1);
    check("rst_busy_h1", m_busy, 0);

    // A5 frame with a dropped request at cycle 10
    transact(2, 8'hA5, 10);
    idle(3);

    // Same code again: skipped, no SPI activity
    transact(2, 8'hA5, 0);
    idle(2);

    // Back-to-back: second request in the idle cycle after done
    transact(2, 8'h11, 0);
    transact(2, 8'h3C, 0);
    idle(2);

    // Reset in the middle of bit 7
    sel_h = 2;
    drive(1'b1, 8'h5A);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      drive(1'b0, 8'h5A);
    end
    check("pre_rst_cs_n", m_cs_n, 0);
    check("pre_rst_sclk", m_sclk, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", m_cs_n, 1);
    check("abort_sclk", m_sclk, 0);
    check("abort_mosi", m_mosi, 0);
    check("abort_busy", m_busy, 0);
    check("abort_done", m_done, 0);
    check("abort_code", m_code, 8'h00);
    model1 = 8'h00;
    model2 = 8'h00;
    idle(2);
    rst = 1'b0;
    idle(1);
    transact(2, 8'h5A, 0);
    idle(2);

    // H=1: sclk toggles every cycle
    transact(1, 8'hFF, 0);
    idle(2);

    // Random requests on both instances
    for (int i = 0; i < 10; i++) begin
      h    = (i % 2 == 1) ? 1 : 2;
      code = 8'($urandom_range(0, 255));
      if (i == 4) code = (h == 1) ? model1 : model2;
      if (i == 6) drop_at = 34 * h + 1;
      else if ($urandom_range(0, 2) == 0) drop_at = $urandom_range(2, 30 * h);
      else drop_at = 0;
      transact(h, code, drop_at);
      idle($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
